// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a per-grant hold limit.
// Grants are registered; the pointer rotates past the holder on release or timeout.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid
);

  localparam int unsigned CntW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_HOLD - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          r_state;
  logic [2:0]      r_ptr;
  logic [CntW-1:0] r_cnt;
  logic [7:0]      r_grant;
  logic [2:0]      r_grant_idx;
  logic            r_grant_valid;

  logic            w_hold;
  logic [2:0]      w_base;
  logic [15:0]     w_dbl;
  logic [7:0]      w_rot;
  logic            w_found;
  logic [2:0]      w_off;
  logic [2:0]      w_win;

  always_comb begin
    w_hold = (r_state == StBusy) && req[r_grant_idx] && (r_cnt < CntLast);
    // In BUSY the search already starts past the holder, so a release or
    // timeout re-arbitrates in the same cycle with the rotated pointer.
    w_base = (r_state == StBusy) ? r_grant_idx + 3'd1 : r_ptr;
    w_dbl   = {req, req} >> w_base;
    w_rot   = w_dbl[7:0];
    w_found = |w_rot;
    w_off   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = 3'(i);
      end
    end
    w_win = w_base + w_off;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_ptr         <= 3'd0;
      r_cnt         <= '0;
      r_grant       <= 8'h00;
      r_grant_idx   <= 3'd0;
      r_grant_valid <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_state       <= StBusy;
            r_grant       <= 8'h01 << w_win;
            r_grant_idx   <= w_win;
            r_grant_valid <= 1'b1;
            r_cnt         <= '0;
          end
        end
        StBusy: begin
          if (w_hold) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_ptr <= w_base;
            if (w_found) begin
              r_grant       <= 8'h01 << w_win;
              r_grant_idx   <= w_win;
              r_grant_valid <= 1'b1;
              r_cnt         <= '0;
            end else begin
              r_state       <= StIdle;
              r_grant       <= 8'h00;
              r_grant_valid <= 1'b0;
              r_cnt         <= '0;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_grant_idx;
  assign grant_valid = r_grant_valid;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: three instances (MAX_HOLD 4, 1, default) checked
// against scoreboard expectations and a reference model for random traffic.
module tb_rr_arbiter_8;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] idx;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req4, req1, req16;
  logic [7:0] g4, g1, g16;
  logic [2:0] i4, i1, i16;
  logic       v4, v1, v16;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state for the MAX_HOLD=4 instance
  bit   m_valid;
  int   m_idx, m_cnt, m_ptr;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .grant(g4), .grant_idx(i4), .grant_valid(v4)
  );
  rr_arbiter_8 #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .grant(g1), .grant_idx(i1), .grant_valid(v1)
  );
  rr_arbiter_8 dut16 (
    .clk(clk), .rst_n(rst_n), .req(req16), .grant(g16), .grant_idx(i16), .grant_valid(v16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req4 = 8'h00; req1 = 8'h00; req16 = 8'h00;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t obs;
    req4 = 8'hFF; req1 = 8'hFF; req16 = 8'hFF;
    rst_n = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      obs = (k == 0) ? {g4, i4, v4} : (k == 1) ? {g1, i1, v1} : {g16, i16, v16};
      n_cmp++;
      if (obs !== exp_t'('0)) begin
        n_err++;
        $display("FAIL reset inst%0d: got g=%h idx=%0d v=%b, want g=00 idx=0 v=0",
                 k, obs.g, obs.idx, obs.v);
      end
    end
    req4 = 8'h00; req1 = 8'h00; req16 = 8'h00;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] stim [4] = '{8'h81, 8'h80, 8'h00, 8'h00};
    exp_t       want [4] = '{{8'h01, 3'd0, 1'b1}, {8'h80, 3'd7, 1'b1},
                             {8'h00, 3'd7, 1'b0}, {8'h00, 3'd7, 1'b0}};
    exp_t e, obs;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      req16 = stim[k];
      sb_q.push_back(want[k]);
      tick();
      e   = sb_q.pop_front();
      obs = {g16, i16, v16};
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL basic step%0d: got g=%h idx=%0d v=%b, want g=%h idx=%0d v=%b",
                 k, obs.g, obs.idx, obs.v, e.g, e.idx, e.v);
      end
    end
  endtask

  task automatic test_idle_ptr();
    logic [7:0] stim [5] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'hFF};
    exp_t       want [5] = '{{8'h04, 3'd2, 1'b1}, {8'h00, 3'd2, 1'b0}, {8'h00, 3'd2, 1'b0},
                             {8'h00, 3'd2, 1'b0}, {8'h08, 3'd3, 1'b1}};
    exp_t e, obs;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      req16 = stim[k];
      sb_q.push_back(want[k]);
      tick();
      e   = sb_q.pop_front();
      obs = {g16, i16, v16};
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL idle_ptr step%0d: got g=%h idx=%0d v=%b, want g=%h idx=%0d v=%b",
                 k, obs.g, obs.idx, obs.v, e.g, e.idx, e.v);
      end
    end
  endtask

  task automatic test_timeout_rotate();
    exp_t e, obs;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      req4 = 8'h06;
      if (k >= 4 && k < 8) sb_q.push_back({8'h04, 3'd2, 1'b1});
      else                 sb_q.push_back({8'h02, 3'd1, 1'b1});
      tick();
      e   = sb_q.pop_front();
      obs = {g4, i4, v4};
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL timeout_rotate cyc%0d: got g=%h idx=%0d v=%b, want g=%h idx=%0d v=%b",
                 k, obs.g, obs.idx, obs.v, e.g, e.idx, e.v);
      end
    end
  endtask

  task automatic test_sole_requester();
    exp_t       e, obs;
    logic [1:0] want_cnt;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      req4 = 8'h10;
      sb_q.push_back({8'h10, 3'd4, 1'b1});
      tick();
      e        = sb_q.pop_front();
      obs      = {g4, i4, v4};
      want_cnt = 2'(k % 4);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL sole cyc%0d: got g=%h idx=%0d v=%b, want g=%h idx=%0d v=%b",
                 k, obs.g, obs.idx, obs.v, e.g, e.idx, e.v);
      end
      n_cmp++;
      if (dut4.r_cnt !== want_cnt) begin
        n_err++;
        $display("FAIL sole_cnt cyc%0d: got %0d, want %0d", k, dut4.r_cnt, want_cnt);
      end
    end
  endtask

  task automatic test_max_hold_1();
    exp_t e, obs;
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      req1 = 8'hFF;
      sb_q.push_back({8'h01 << (k % 8), 3'(k % 8), 1'b1});
      tick();
      e   = sb_q.pop_front();
      obs = {g1, i1, v1};
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL max_hold_1 cyc%0d: got g=%h idx=%0d v=%b, want g=%h idx=%0d v=%b",
                 k, obs.g, obs.idx, obs.v, e.g, e.idx, e.v);
      end
    end
  endtask

  task automatic test_no_preempt();
    logic [7:0] stim [4] = '{8'h08, 8'h0F, 8'hFF, 8'h07};
    exp_t       want [4] = '{{8'h08, 3'd3, 1'b1}, {8'h08, 3'd3, 1'b1},
                             {8'h08, 3'd3, 1'b1}, {8'h01, 3'd0, 1'b1}};
    exp_t e, obs;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      req4 = stim[k];
      sb_q.push_back(want[k]);
      tick();
      e   = sb_q.pop_front();
      obs = {g4, i4, v4};
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL no_preempt step%0d: got g=%h idx=%0d v=%b, want g=%h idx=%0d v=%b",
                 k, obs.g, obs.idx, obs.v, e.g, e.idx, e.v);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic rstv [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_t want [5] = '{{8'h08, 3'd3, 1'b1}, {8'h08, 3'd3, 1'b1}, {8'h08, 3'd3, 1'b1},
                       {8'h00, 3'd0, 1'b0}, {8'h08, 3'd3, 1'b1}};
    exp_t e, obs;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      req16 = 8'h08;
      rst_n = rstv[k];
      sb_q.push_back(want[k]);
      tick();
      e   = sb_q.pop_front();
      obs = {g16, i16, v16};
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL reset_mid_hold step%0d: got g=%h idx=%0d v=%b, want g=%h idx=%0d v=%b",
                 k, obs.g, obs.idx, obs.v, e.g, e.idx, e.v);
      end
      if (k == 2) begin
        n_cmp++;
        if (dut16.r_cnt !== 4'd2) begin
          n_err++;
          $display("FAIL reset_mid_hold_cnt: got %0d, want 2", dut16.r_cnt);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic model_step(input logic [7:0] r, output exp_t e);
    bit rearb;
    bit found;
    int j;
    rearb = 1'b1;
    if (m_valid) begin
      if (r[m_idx] && (m_cnt < 3)) begin
        m_cnt++;
        rearb = 1'b0;
      end else begin
        m_ptr = (m_idx + 1) % 8;
      end
    end
    if (rearb) begin
      found = 1'b0;
      for (int k = 0; k < 8; k++) begin
        j = (m_ptr + k) % 8;
        if (!found && r[j]) begin
          found = 1'b1;
          m_idx = j;
          m_cnt = 0;
        end
      end
      m_valid = found;
    end
    e.g   = m_valid ? (8'h01 << m_idx) : 8'h00;
    e.idx = 3'(m_idx);
    e.v   = m_valid;
  endtask

  task automatic test_random();
    exp_t       e, obs;
    logic [7:0] r;
    int         wt [8];
    int         worst;
    apply_reset();
    m_valid = 1'b0; m_idx = 0; m_cnt = 0; m_ptr = 0;
    for (int i = 0; i < 8; i++) wt[i] = 0;
    r = 8'h00;
    for (int c = 0; c < 20000; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(7) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(63) == 0) r = 8'h00;
      req4 = r;
      model_step(r, e);
      sb_q.push_back(e);
      tick();
      e   = sb_q.pop_front();
      obs = {g4, i4, v4};
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL random_model cyc%0d req=%h: got g=%h idx=%0d v=%b, want g=%h idx=%0d v=%b",
                 c, r, obs.g, obs.idx, obs.v, e.g, e.idx, e.v);
      end
      n_cmp++;
      if ($countones(g4) > 1 || g4 !== (v4 ? (8'h01 << i4) : 8'h00)) begin
        n_err++;
        $display("FAIL random_onehot cyc%0d: got g=%h idx=%0d v=%b, want one-hot matching idx",
                 c, g4, i4, v4);
      end
      worst = 0;
      for (int i = 0; i < 8; i++) begin
        if (r[i] && !g4[i]) wt[i]++;
        else                wt[i] = 0;
        if (wt[i] > worst) worst = wt[i];
      end
      n_cmp++;
      if (worst > 28) begin
        n_err++;
        $display("FAIL random_wait cyc%0d: got %0d edges waiting, want at most 28", c, worst);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req4 = 8'h00; req1 = 8'h00; req16 = 8'h00;
    test_reset();
    test_basic();
    test_idle_ptr();
    test_timeout_rotate();
    test_sole_requester();
    test_max_hold_1();
    test_no_preempt();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
